alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Multi-cycle request initiator that sits in front of the 32-bit ALU in the crypto datapath. It accepts one macro-operation per valid/ready handshake and drives the ALU's 4-bit control code and operand buses over one to three passes. It combines intermediate results internally and returns a single result plus a zero flag on a valid/ready response channel. This adds rotate, and-not and set-equal operations that crypto rounds need, without widening the ALU.

## Interface
- `DATA_W`, default 32: datapath width. It is fixed at 32 to match the ALU; other values are unsupported.
- `SHAMT_W`, default 5: shift-amount width.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the sequencer can accept a request.
- `req_op` in 4: macro-op code.
- `req_a` in 32: operand A.
- `req_b` in 32: operand B, or the shift/rotate amount in `req_b[4:0]`.
- `rsp_valid` out 1: the response is valid.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_result` out 32: final result.
- `rsp_zero` out 1: set when `rsp_result == 0`. It is computed locally; the ALU zero flag is not used.
- `alu_control` out 4: control code to the ALU.
- `alu_a` out 32: operand A to the ALU.
- `alu_b` out 32: operand B to the ALU.
- `alu_result` in 32: combinational result from the ALU, sampled in the same cycle.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **Single-pass ops (1 pass).** `req_op` is passed straight through as `alu_control`, with `alu_a = A` and `alu_b = B`. These are:
  - 0x0 AND, 0x1 OR, 0x2 ADD, 0x3 XOR, 0x4 NOR, 0x5 NAND, 0x6 SUB
  - 0x7 SLT, 0x8 SLTU
  - 0xC SLL, 0xD SRL, 0xF SRA
- **0x9 ROTL (3 passes).**
  - P1: SLL(A, n) → t1.
  - P2: SRL(A, m) → t2.
  - P3: OR(t1, t2) → result.
  - n = B[4:0] and m = (0 − n) mod 32, a 5-bit wrap, zero-extended onto `alu_b`.
  - When n = 0, m = 0 and the result is A.
- **0xA ROTR (3 passes).**
  - P1: SRL(A, n) → t1.
  - P2: SLL(A, m) → t2.
  - P3: OR(t1, t2) → result.
- **0xB ANDN (2 passes).**
  - P1: NOR(B, B) → t1.
  - P2: AND(A, t1) → result.
- **0xE SEQ (2 passes).**
  - P1: XOR(A, B) → t1.
  - P2: SLTU(t1, 32'd1) → result, which is 1 if A == B, else 0.
- **State machine.** States are IDLE, P1, P2, P3, RESP.
  - IDLE → P1 when `req_valid` is high: latch op, A and B.
  - P1 → RESP for single-pass ops. P1 → P2 otherwise.
  - P2 → RESP for ANDN and SEQ. P2 → P3 for rotates.
  - P3 → RESP.
  - RESP → IDLE when `rsp_ready` is high. RESP holds otherwise.
- **Pass behaviour.** In each pass state the ALU ports are driven combinationally from the latched registers. `alu_result` is captured at the end of that cycle into t1, t2 or the result register.
- On the final pass, `rsp_result` and `rsp_zero` are registered.
- In IDLE and RESP, `alu_control = 0` and `alu_a = alu_b = 0`.
- `req_ready = (state == IDLE)`. Requests offered in any other state are ignored and not latched.
- Response outputs stay stable throughout RESP.
- **Reset values:**
  - state = IDLE
  - `req_ready` = 1
  - `rsp_valid` = 0, `rsp_result` = 0, `rsp_zero` = 0
  - `alu_*` = 0
  - `busy` = 0
  - t1, t2 and the latched operands = 0
- **Reset mid-operation:** the next edge goes to IDLE and the operation is dropped with no response.

## Timing
- The request is accepted at the edge where `req_valid && req_ready`.
- An N-pass op asserts `rsp_valid` N edges after acceptance: ADD after 1, SEQ after 2, ROTL after 3.
- Response transfer happens at the edge where `rsp_valid && rsp_ready`.
- `req_ready` rises the cycle after the response transfer.
- Minimum issue interval is N+2 cycles when `rsp_ready` is tied high.
- A stalled `rsp_ready` blocks new requests indefinitely. There is no timeout.
- `alu_result` must settle within one cycle; no ALU pipelining is assumed.
- Undefined op codes (none remain among the 16) are not applicable. All 4-bit codes are defined above.

## Test plan
- ADD, A=0xFFFFFFFF, B=1, `rsp_ready`=1 → `rsp_valid` 1 edge after accept, `rsp_result`=0x00000000, `rsp_zero`=1, `alu_control`=0x2 during P1.
- ROTL, A=0x80000001, B=4 → `alu_control` sequence 0xC, 0xD, 0x1 with `alu_b` = 4, 28, t2; `rsp_result`=0x00000018 after 3 edges. Then ROTL with B=0 → `rsp_result`=0x80000001.
- ROTR, A=0x12345678, B=8 → `rsp_result`=0x78123456, `rsp_zero`=0.
- ANDN, A=0xFF00FF00, B=0x0F0F0F0F → 0xF000F000. SEQ with A=B=0xDEADBEEF → 0x00000001. SEQ with A=0, B=1 → 0x00000000 and `rsp_zero`=1.
- SRA, A=0x80000000, B=31, with `rsp_ready` held low 5 cycles → `rsp_result`=0xFFFFFFFF held stable; `req_ready`=0 and `busy`=1 throughout; a `req_valid` pulse meanwhile is not accepted. Then `rsp_ready`=1 → IDLE next edge.
- ROTR accepted, then `rst_n`=0 for one cycle during P2 → next edge state IDLE, `rsp_valid` stays 0, `alu_*`=0, and no response is ever produced for the dropped op.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer_if
// Bundles the three channels around alu_op_sequencer:
//   request  : req_valid / req_ready / req_op / req_a / req_b
//   response : rsp_valid / rsp_ready / rsp_result / rsp_zero
//   ALU bus  : alu_control / alu_a / alu_b out, alu_result back in
//   status   : busy
// Modports:
//   master : the environment side (request producer, response consumer,
//            and the combinational ALU answering on alu_result)
//   slave  : the sequencer itself
// ----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;

    logic [3:0]        alu_control;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;

    logic              busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_result, rsp_zero,
               alu_control, alu_a, alu_b, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_result, rsp_zero,
               alu_control, alu_a, alu_b, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
// Multi-cycle front end for the 32-bit ALU. Accepts one macro-op per
// request handshake, runs it as one to three ALU passes and returns a single
// result plus a locally computed zero flag on the response channel.
// Adds ROTL, ROTR, ANDN and SEQ on top of the ALU's native operations.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous, active-low reset
//   bus   : alu_op_sequencer_if.slave (request, response, ALU bus, busy)
// ----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_op_sequencer_if.slave    bus
);

    // Macro-op codes; native ALU codes pass through unchanged.
    typedef enum logic [3:0] {
        OP_AND  = 4'h0,
        OP_OR   = 4'h1,
        OP_ADD  = 4'h2,
        OP_XOR  = 4'h3,
        OP_NOR  = 4'h4,
        OP_NAND = 4'h5,
        OP_SUB  = 4'h6,
        OP_SLT  = 4'h7,
        OP_SLTU = 4'h8,
        OP_ROTL = 4'h9,
        OP_ROTR = 4'hA,
        OP_ANDN = 4'hB,
        OP_SLL  = 4'hC,
        OP_SRL  = 4'hD,
        OP_SEQ  = 4'hE,
        OP_SRA  = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_P2,
        S_P3,
        S_RESP
    } state_e;

    state_e             state;
    op_e                op_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  t1_q;
    logic [DATA_W-1:0]  t2_q;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_result_q;
    logic               rsp_zero_q;

    // Shift amount n and its complement m = (0 - n) mod 2^SHAMT_W. With
    // n = 0 both shifts are identity and the OR pass returns A unchanged.
    logic [SHAMT_W-1:0] n_amt;
    logic [SHAMT_W-1:0] m_amt;
    logic [DATA_W-1:0]  n_ext;
    logic [DATA_W-1:0]  m_ext;

    assign n_amt = b_q[SHAMT_W-1:0];
    assign m_amt = SHAMT_W'(0) - n_amt;
    assign n_ext = {{(DATA_W-SHAMT_W){1'b0}}, n_amt};
    assign m_ext = {{(DATA_W-SHAMT_W){1'b0}}, m_amt};

    // Number of ALU passes the latched op needs.
    logic [1:0] num_passes;
    always_comb begin
        case (op_q)
            OP_ROTL, OP_ROTR: num_passes = 2'd3;
            OP_ANDN, OP_SEQ:  num_passes = 2'd2;
            default:          num_passes = 2'd1;
        endcase
    end

    logic last_pass;
    assign last_pass = ((state == S_P1) && (num_passes == 2'd1)) ||
                       ((state == S_P2) && (num_passes == 2'd2)) ||
                        (state == S_P3);

    // ALU drive: decoded from state and latched registers only, so the ALU
    // bus never depends combinationally on the request inputs.
    logic [3:0]        alu_control_c;
    logic [DATA_W-1:0] alu_a_c;
    logic [DATA_W-1:0] alu_b_c;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; that is what keeps this block free of inferred latches.
        alu_control_c = OP_AND;
        alu_a_c       = '0;
        alu_b_c       = '0;
        case (state)
            S_P1: begin
                case (op_q)
                    OP_ROTL: begin alu_control_c = OP_SLL; alu_a_c = a_q; alu_b_c = n_ext; end
                    OP_ROTR: begin alu_control_c = OP_SRL; alu_a_c = a_q; alu_b_c = n_ext; end
                    OP_ANDN: begin alu_control_c = OP_NOR; alu_a_c = b_q; alu_b_c = b_q;   end
                    OP_SEQ:  begin alu_control_c = OP_XOR; alu_a_c = a_q; alu_b_c = b_q;   end
                    default: begin alu_control_c = op_q;   alu_a_c = a_q; alu_b_c = b_q;   end
                endcase
            end
            S_P2: begin
                case (op_q)
                    OP_ROTL: begin alu_control_c = OP_SRL;  alu_a_c = a_q;  alu_b_c = m_ext; end
                    OP_ROTR: begin alu_control_c = OP_SLL;  alu_a_c = a_q;  alu_b_c = m_ext; end
                    OP_ANDN: begin alu_control_c = OP_AND;  alu_a_c = a_q;  alu_b_c = t1_q;  end
                    // t1 = A ^ B; (t1 < 1) unsigned is exactly (A == B).
                    OP_SEQ:  begin alu_control_c = OP_SLTU; alu_a_c = t1_q; alu_b_c = DATA_W'(1); end
                    default: ;
                endcase
            end
            S_P3: begin
                alu_control_c = OP_OR;
                alu_a_c       = t1_q;
                alu_b_c       = t2_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, and it clears the datapath registers
        // (operands, t1/t2, result) too, so a dropped op leaves nothing behind.
        if (!rst_n) begin
            state        <= S_IDLE;
            op_q         <= OP_AND;
            a_q          <= '0;
            b_q          <= '0;
            t1_q         <= '0;
            t2_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here samples pre-edge values regardless of statement order.
            if (last_pass) begin
                rsp_result_q <= bus.alu_result;
                rsp_zero_q   <= (bus.alu_result == '0);
                rsp_valid_q  <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q  <= op_e'(bus.req_op);
                        a_q   <= bus.req_a;
                        b_q   <= bus.req_b;
                        state <= S_P1;
                    end
                end
                S_P1: begin
                    if (last_pass) begin
                        state <= S_RESP;
                    end else begin
                        t1_q  <= bus.alu_result;
                        state <= S_P2;
                    end
                end
                S_P2: begin
                    if (last_pass) begin
                        state <= S_RESP;
                    end else begin
                        t2_q  <= bus.alu_result;
                        state <= S_P3;
                    end
                end
                S_P3: begin
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = (state == S_IDLE);
    assign bus.busy        = (state != S_IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.alu_control = alu_control_c;
    assign bus.alu_a       = alu_a_c;
    assign bus.alu_b       = alu_b_c;

endmodule
